mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the width of each channel word.
REQ-002 Parameter DWELL_W, default 8, SHALL set the width of the dwell count.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 wr_en  input  1  SHALL be the channel-register write strobe.
REQ-006 wr_addr  input  3  SHALL give the channel index written, 0=a through 7=h.
REQ-007 wr_data  input  DATA_W  SHALL be the write data.
REQ-008 start  input  1  SHALL request a scan, sampled in IDLE only.
REQ-009 stop  input  1  SHALL abort a scan.
REQ-010 continuous  input  1  SHALL select wrap-around (1) or single-frame (0) mode, latched at start.
REQ-011 dwell  input  DWELL_W  SHALL give the cycles spent per channel, latched at start.
REQ-012 ch_a..ch_h  output  DATA_W each  SHALL present the eight channel registers to the downstream 8x1 mux data inputs.
REQ-013 sel0, sel1, sel2  output  1 each  SHALL drive the mux select, {sel2,sel1,sel0} = current channel index.
REQ-014 busy  output  1  SHALL be high while in SCAN.
REQ-015 step  output  1  SHALL pulse for one cycle on every channel advance.
REQ-016 frame_done  output  1  SHALL pulse for one cycle when channel 7 completes its dwell.

Function
REQ-017 FSM states SHALL be IDLE and SCAN only.
REQ-018 In IDLE, start=1 and stop=0 SHALL latch dwell and continuous, clear index and dwell counter, and enter SCAN; busy rises the following cycle.
REQ-019 A latched dwell of 0 SHALL be treated as 1.
REQ-020 In SCAN the dwell counter SHALL increment every cycle; at count == dwell_lat-1 it SHALL clear, index SHALL increment, and step SHALL pulse in that same cycle.
REQ-021 Terminal count at index 7 SHALL pulse frame_done together with step. With continuous_lat=1, index wraps to 0 and the block stays in SCAN. With continuous_lat=0, index returns to 0 and the FSM enters IDLE.
REQ-022 stop=1 in SCAN SHALL force IDLE and index 0 next cycle, with no step or frame_done, even when it coincides with terminal count.
REQ-023 start in SCAN SHALL be ignored; stop in IDLE SHALL be ignored; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-024 Changes to dwell or continuous while in SCAN SHALL have no effect until the next start.
REQ-025 wr_en SHALL be honoured in any state; the written value appears on ch_<addr> the cycle after the write, including the currently selected channel.
REQ-026 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 at a clock edge SHALL clear ch_a..ch_h to 0, index to 0 (sel2..sel0=0), busy, step and frame_done to 0, the dwell counter and latches to 0, and the FSM to IDLE.
REQ-028 Reset SHALL take priority over every other input, including mid-scan and coincident writes.

Structure
REQ-029 State encodings and the channel-count constant (8) SHALL live in a shared `include header used by this block and its bench.
REQ-030 The dwell counter with terminal-count output SHALL be a separate sub-module, dwell_counter; the channel register file stays inline.

Verification
REQ-031 Reset: after writes and mid-scan, assert rst_n=0 for 1 cycle -> all ch_* = 0, sel = 0, busy = 0 next cycle.
REQ-032 Single frame: write a..h = 0,15,2,3,12,5,10,7; dwell = 20, continuous = 0, pulse start -> sel steps 0..7 every 20 cycles, frame_done after 160 cycles, then busy = 0; the mux output follows 0,15,2,3,12,5,10,7.
REQ-033 Continuous with dwell = 0: each channel is held 1 cycle, sel wraps 7 -> 0, frame_done every 8 cycles, step every cycle.
REQ-034 Stop at terminal count: dwell = 3, assert stop on the cycle index 7 reaches count 2 -> no frame_done, IDLE, sel = 0.
REQ-035 Live write: while sel = 4 in SCAN, write addr 4 = 9 -> ch_e = 9 the next cycle, no effect on sequencing.
REQ-036 Ignored inputs: start pulsed mid-scan, and start with stop in IDLE -> no change in sel, busy or dwell latch.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the 8-channel mux scan sequencer: channel count,
// channel index type and FSM state encoding. Imported by the RTL and the bench.
package mux_scan_sequencer_pkg;

    // Number of channels feeding the downstream 8x1 mux
    localparam int NUM_CH = 8;

    // Width of a channel index (3 bits selects one of eight channels)
    localparam int IDX_W = $clog2(NUM_CH);

    typedef logic [IDX_W-1:0] ch_idx_t;

    // Index of the final channel in a frame; its terminal count ends the frame
    localparam ch_idx_t LAST_CH = ch_idx_t'(NUM_CH - 1);

    // The sequencer only ever waits for a start or walks the channels
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bus bundle for the mux scan sequencer: register-write port, scan control,
// the eight channel words, mux select lines and scan status pulses.
interface mux_scan_sequencer_if #(
    parameter int DATA_W  = 4,
    parameter int DWELL_W = 8
) ();

    // Channel register write port
    logic                            wr_en;
    mux_scan_sequencer_pkg::ch_idx_t wr_addr;
    logic [DATA_W-1:0]               wr_data;

    // Scan control
    logic                            start;
    logic                            stop;
    logic                            continuous;
    logic [DWELL_W-1:0]              dwell;

    // Channel words presented to the downstream mux data inputs
    logic [DATA_W-1:0]               ch_a;
    logic [DATA_W-1:0]               ch_b;
    logic [DATA_W-1:0]               ch_c;
    logic [DATA_W-1:0]               ch_d;
    logic [DATA_W-1:0]               ch_e;
    logic [DATA_W-1:0]               ch_f;
    logic [DATA_W-1:0]               ch_g;
    logic [DATA_W-1:0]               ch_h;

    // Mux select and status
    logic                            sel0;
    logic                            sel1;
    logic                            sel2;
    logic                            busy;
    logic                            step;
    logic                            frame_done;

    // Controller side: drives writes and scan control, observes the outputs
    modport master (
        output wr_en, wr_addr, wr_data,
        output start, stop, continuous, dwell,
        input  ch_a, ch_b, ch_c, ch_d, ch_e, ch_f, ch_g, ch_h,
        input  sel0, sel1, sel2, busy, step, frame_done
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  start, stop, continuous, dwell,
        output ch_a, ch_b, ch_c, ch_d, ch_e, ch_f, ch_g, ch_h,
        output sel0, sel1, sel2, busy, step, frame_done
    );

endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Dwell counter: counts cycles spent on the current channel and flags the
// last cycle of the dwell. A dwell of 0 behaves exactly like a dwell of 1.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               terminal
);

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] last;

    // Final count value of a dwell; zero and one both give a one-cycle dwell
    always_comb begin
        last = '0;
        if (dwell != '0) begin
            last = dwell - DWELL_W'(1);
        end
    end

    assign terminal = run && (count == last);

    // Count while running, wrap at terminal count, hold at zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || terminal) begin
            count <= '0;
        end else begin
            count <= count + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: holds eight writable channel words and walks the mux
// select across them, spending a latched number of cycles on each channel.
// Runs one frame or wraps continuously; stop aborts at once.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sequencer_if.slave   bus
);

    scan_state_t        state;
    ch_idx_t            index;
    logic               busy;
    logic               step;
    logic               frame_done;
    logic [DWELL_W-1:0] dwell_lat;
    logic               cont_lat;

    logic [DATA_W-1:0]  ch_reg [NUM_CH];

    logic               run;
    logic               terminal;

    // The counter only advances in SCAN; a stop clears it along with the FSM
    assign run = (state == SCAN) && !bus.stop;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .dwell    (dwell_lat),
        .terminal (terminal)
    );

    // Channel register file, writable in any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_reg[i] <= '0;
            end
        end else if (bus.wr_en) begin
            ch_reg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scan FSM with registered select, busy and pulse outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            busy       <= 1'b0;
            step       <= 1'b0;
            frame_done <= 1'b0;
            dwell_lat  <= '0;
            cont_lat   <= 1'b0;
        end else begin
            step       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        dwell_lat <= bus.dwell;
                        cont_lat  <= bus.continuous;
                        index     <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        index <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (terminal) begin
                        step <= 1'b1;
                        if (index == LAST_CH) begin
                            frame_done <= 1'b1;
                            index      <= '0;
                            if (!cont_lat) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            index <= index + ch_idx_t'(1);
                        end
                    end
                end
                default: begin
                    index <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ch_a       = ch_reg[0];
    assign bus.ch_b       = ch_reg[1];
    assign bus.ch_c       = ch_reg[2];
    assign bus.ch_d       = ch_reg[3];
    assign bus.ch_e       = ch_reg[4];
    assign bus.ch_f       = ch_reg[5];
    assign bus.ch_g       = ch_reg[6];
    assign bus.ch_h       = ch_reg[7];

    assign bus.sel0       = index[0];
    assign bus.sel1       = index[1];
    assign bus.sel2       = index[2];
    assign bus.busy       = busy;
    assign bus.step       = step;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. The reference model describes
// each scan as a time window [start, end) with a fixed dwell: inside it the
// selected channel is ((cycle - start) / dwell) mod 8, and a step is expected
// every dwell cycles. Expected steps are queued when a scan is issued and a
// monitor pops them as the DUT pulses step.
module tb_mux_scan_sequencer;
    import mux_scan_sequencer_pkg::*;

    localparam int DATA_W  = 4;
    localparam int DWELL_W = 8;
    localparam int HORIZON = 2000;

    typedef struct {
        int cyc;
        int sel;
        bit fd;
    } step_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mux_scan_sequencer_if #(.DATA_W(DATA_W), .DWELL_W(DWELL_W)) bus ();

    mux_scan_sequencer #(
        .DATA_W  (DATA_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    step_exp_t         exp_q[$];
    int                cyc    = 0;
    int                checks = 0;
    int                errors = 0;
    bit                mon_en = 1'b0;
    int                scan_s = 0;
    int                scan_e = 0;
    int                scan_d = 1;
    logic [DATA_W-1:0] ref_ch [NUM_CH];

    // Count rising edges; at a falling edge cyc equals the edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Channel word model: reset clears, otherwise a write lands on the edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) ref_ch[i] <= '0;
        end else if (bus.wr_en) begin
            ref_ch[bus.wr_addr] <= bus.wr_data;
        end
    end

    function automatic bit active_at(input int c);
        return (c >= scan_s) && (c < scan_e);
    endfunction

    function automatic int exp_sel(input int c);
        if (!active_at(c)) return 0;
        return ((c - scan_s) / scan_d) % NUM_CH;
    endfunction

    function automatic logic [DATA_W-1:0] dut_ch(input logic [2:0] i);
        case (i)
            3'd0:    return bus.ch_a;
            3'd1:    return bus.ch_b;
            3'd2:    return bus.ch_c;
            3'd3:    return bus.ch_d;
            3'd4:    return bus.ch_e;
            3'd5:    return bus.ch_f;
            3'd6:    return bus.ch_g;
            default: return bus.ch_h;
        endcase
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_scan(input int s, input int dw, input bit cont);
        step_exp_t e;
        int        last;
        scan_s = s;
        scan_d = (dw == 0) ? 1 : dw;
        scan_e = cont ? (s + HORIZON + 1) : (s + NUM_CH * scan_d);
        last   = cont ? (s + HORIZON) : (s + NUM_CH * scan_d);
        for (int k = 1; s + k * scan_d <= last; k++) begin
            e.cyc = s + k * scan_d;
            e.sel = k % NUM_CH;
            e.fd  = (k % NUM_CH) == 0;
            exp_q.push_back(e);
        end
    endtask

    // Drive one cycle of inputs and update the model for the coming edge
    task automatic apply_stimulus(input bit rst, input bit we, input int wa, input int wd,
                                  input bit st, input bit sp, input bit cont, input int dw);
        int p;
        p              = cyc + 1;
        rst_n          = !rst;
        bus.wr_en      = we;
        bus.wr_addr    = wa[2:0];
        bus.wr_data    = wd[DATA_W-1:0];
        bus.start      = st;
        bus.stop       = sp;
        bus.continuous = cont;
        bus.dwell      = dw[DWELL_W-1:0];
        if (active_at(p - 1) && (rst || sp)) begin
            scan_e = p;
            while (exp_q.size() > 0 && exp_q[$].cyc >= p) void'(exp_q.pop_back());
        end else if (!rst && !active_at(p - 1) && st && !sp) begin
            start_scan(p, dw, cont);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare every observable output against the model for this cycle
    task automatic check_output();
        logic [2:0]               sel_act;
        logic [NUM_CH*DATA_W-1:0] ref_pack;
        bit                       exp_step;
        int                       c;
        c       = cyc;
        sel_act = {bus.sel2, bus.sel1, bus.sel0};
        for (int i = 0; i < NUM_CH; i++) ref_pack[i*DATA_W +: DATA_W] = ref_ch[i];
        compare("busy", 64'(bus.busy), 64'(active_at(c)));
        compare("sel", 64'(sel_act), 64'(exp_sel(c)));
        compare("channels", 64'({bus.ch_h, bus.ch_g, bus.ch_f, bus.ch_e,
                                 bus.ch_d, bus.ch_c, bus.ch_b, bus.ch_a}), 64'(ref_pack));
        while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_step: no step seen, expected one at cycle %0d (now %0d)",
                     exp_q[0].cyc, c);
            void'(exp_q.pop_front());
        end
        exp_step = (exp_q.size() > 0) && (exp_q[0].cyc == c);
        compare("step", 64'(bus.step), 64'(exp_step));
        compare("frame_done", 64'(bus.frame_done), exp_step ? 64'(exp_q[0].fd) : 64'(0));
        if (exp_step) begin
            compare("step_sel", 64'(sel_act), 64'(exp_q[0].sel));
            compare("mux_out", 64'(dut_ch(sel_act)), 64'(ref_ch[exp_q[0].sel[2:0]]));
            void'(exp_q.pop_front());
        end
    endtask

    always @(negedge clk) if (mon_en) check_output();

    initial begin
        int vals[NUM_CH];
        int s;
        int d;
        int n;
        bit c;
        vals = '{0, 15, 2, 3, 12, 5, 10, 7};
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.dwell      = '0;
        rst_n          = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Single frame, dwell 20, with a live write to channel e and an ignored start
        for (int i = 0; i < NUM_CH; i++) apply_stimulus(0, 1, i, vals[i], 0, 0, 0, 0);
        s = cyc + 1;
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 20);
        while (active_at(cyc)) begin
            if (cyc == s + 4 * 20 + 5)   apply_stimulus(0, 1, 4, 9, 0, 0, 1, 3);
            else if (cyc == s + 30)      apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1);
            else                         idle(1);
        end
        idle(3);

        // Start together with stop, then stop alone, both in IDLE
        apply_stimulus(0, 0, 0, 0, 1, 1, 1, 5);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Continuous with dwell 0: one cycle per channel
        apply_stimulus(0, 0, 0, 0, 1, 0, 1, 0);
        idle(30);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Stop coinciding with the terminal count of channel 7
        s = cyc + 1;
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 3);
        while (cyc < s + 23) idle(1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Reset mid-scan with a coincident write
        apply_stimulus(0, 0, 0, 0, 1, 0, 1, 2);
        idle(13);
        apply_stimulus(1, 1, 3, 5, 0, 0, 0, 0);
        idle(3);

        // Randomized scans with writes, ignored starts and changing dwell/continuous
        repeat (12) begin
            n = $urandom_range(0, 4);
            repeat (n) apply_stimulus(0, 1, int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 15)), 0, 0, 0, 0);
            d = $urandom_range(0, 4);
            c = 1'($urandom_range(0, 1));
            apply_stimulus(0, 0, 0, 0, 1, 0, c, d);
            if (c)                              n = $urandom_range(4, 60);
            else if ($urandom_range(0, 2) == 0) n = $urandom_range(1, 40);
            else                                n = 1000;
            for (int i = 0; i < n && active_at(cyc); i++) begin
                apply_stimulus(0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, 0,
                               1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end
            if (active_at(cyc)) apply_stimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)), 1, 0, 0);
            idle(2);
        end

        idle(5);
        compare("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
